// File: rtl/rename_unit_if.sv
// rtl/rename_unit_if.sv - rename, writeback and commit signal bundle for rename_unit
//
// Purpose: groups the decode-side rename handshake, the writeback notification and
// the commit/recover notifications between the core and rename_unit.
// Ports (signals):
//   rn_valid/rn_ready                  rename handshake
//   rn_rs1, rn_rs2, rn_rd, rn_rd_we    architectural operands of the offered instruction
//   p_rs1, p_rs2, p_rs1_rdy, p_rs2_rdy physical sources and their availability
//   p_rd_new, p_rd_old                 allocated destination and its previous mapping
//   wb_valid, wb_prd                   result written to a physical register
//   cm_valid, cm_ard, cm_prd_new/old   in-order commit of a renamed writer
//   recover                            flush all speculative state
//   free_count                         registered free-list occupancy
// Modports: master = core side (drives requests), slave = rename_unit.
interface rename_unit_if #(
  parameter int AW = 6,
  parameter int PW = 7
) ();
  logic          rn_valid;
  logic          rn_ready;
  logic [AW-1:0] rn_rs1;
  logic [AW-1:0] rn_rs2;
  logic [AW-1:0] rn_rd;
  logic          rn_rd_we;
  logic [PW-1:0] p_rs1;
  logic [PW-1:0] p_rs2;
  logic          p_rs1_rdy;
  logic          p_rs2_rdy;
  logic [PW-1:0] p_rd_new;
  logic [PW-1:0] p_rd_old;
  logic          wb_valid;
  logic [PW-1:0] wb_prd;
  logic          cm_valid;
  logic [AW-1:0] cm_ard;
  logic [PW-1:0] cm_prd_new;
  logic [PW-1:0] cm_prd_old;
  logic          recover;
  logic [PW:0]   free_count;

  modport master (
    output rn_valid, rn_rs1, rn_rs2, rn_rd, rn_rd_we,
    output wb_valid, wb_prd,
    output cm_valid, cm_ard, cm_prd_new, cm_prd_old, recover,
    input  rn_ready, p_rs1, p_rs2, p_rs1_rdy, p_rs2_rdy, p_rd_new, p_rd_old, free_count
  );

  modport slave (
    input  rn_valid, rn_rs1, rn_rs2, rn_rd, rn_rd_we,
    input  wb_valid, wb_prd,
    input  cm_valid, cm_ard, cm_prd_new, cm_prd_old, recover,
    output rn_ready, p_rs1, p_rs2, p_rs1_rdy, p_rs2_rdy, p_rd_new, p_rd_old, free_count
  );
endinterface

// File: rtl/rename_unit.sv
// rtl/rename_unit.sv - register rename unit with RMT, CMT, circular free list and ready bits
//
// Purpose: renames one instruction per cycle between decode and issue. Sources are
// looked up in the speculative map (RMT), a destination is popped from the free list,
// writebacks set ready bits, commits update the committed map (CMT) and return the
// previous mapping to the free list, and recover restores RMT from CMT.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   rename_unit_if.slave (rename handshake, writeback, commit, recover, free_count)
// Parameters: AREGS architectural regs, PREGS physical regs, ZERO_REG hardwires r0 to p0.
module rename_unit #(
  parameter int AREGS    = 64,
  parameter int PREGS    = 80,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst,
  rename_unit_if.slave bus
);
  localparam int AW     = $clog2(AREGS);
  localparam int PW     = $clog2(PREGS);
  localparam int CW     = PW + 1;
  localparam int FDEPTH = PREGS - AREGS;
  localparam int FW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam logic [FW-1:0] LAST_SLOT  = FW'(FDEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FDEPTH);
  localparam bit            HARD_ZERO  = (ZERO_REG != 0);

  logic [PW-1:0]    r_rmt  [AREGS];
  logic [PW-1:0]    r_cmt  [AREGS];
  logic [PW-1:0]    r_free [FDEPTH];
  logic [FW-1:0]    r_head;
  logic [FW-1:0]    r_tail;
  logic [CW-1:0]    r_free_count;
  logic [PREGS-1:0] r_ready;

  logic          w_rs1_zero;
  logic          w_rs2_zero;
  logic          w_rd_zero;
  logic          w_cm_zero;
  logic          w_alloc;
  logic          w_ready;
  logic          w_fire;
  logic          w_pop;
  logic          w_push;
  logic [PW-1:0] w_p_rs1;
  logic [PW-1:0] w_p_rs2;
  logic [PW-1:0] w_p_rd_new;
  logic [FW-1:0] w_head_inc;
  logic [FW-1:0] w_tail_next;

  // Slot pointers wrap at FDEPTH, which need not be a power of two.
  function automatic logic [FW-1:0] slot_inc(input logic [FW-1:0] idx);
    return (idx == LAST_SLOT) ? '0 : idx + 1'b1;
  endfunction

  assign w_rs1_zero = HARD_ZERO && (bus.rn_rs1 == '0);
  assign w_rs2_zero = HARD_ZERO && (bus.rn_rs2 == '0);
  assign w_rd_zero  = HARD_ZERO && (bus.rn_rd == '0);
  assign w_cm_zero  = HARD_ZERO && (bus.cm_ard == '0);

  assign w_alloc = bus.rn_rd_we && !w_rd_zero;
  // A commit push in this cycle is not visible to the stall decision: free_count is registered.
  assign w_ready = !bus.recover && (!w_alloc || (r_free_count != '0));
  assign w_fire  = bus.rn_valid && w_ready;
  assign w_pop   = w_fire && w_alloc;
  assign w_push  = bus.cm_valid && !w_cm_zero;

  assign w_p_rs1     = w_rs1_zero ? '0 : r_rmt[bus.rn_rs1];
  assign w_p_rs2     = w_rs2_zero ? '0 : r_rmt[bus.rn_rs2];
  assign w_p_rd_new  = r_free[r_head];
  assign w_head_inc  = slot_inc(r_head);
  assign w_tail_next = w_push ? slot_inc(r_tail) : r_tail;

  assign bus.rn_ready   = w_ready;
  assign bus.p_rs1      = w_p_rs1;
  assign bus.p_rs2      = w_p_rs2;
  // Same-cycle writeback is bypassed so a consumer never misses a result.
  assign bus.p_rs1_rdy  = w_rs1_zero || r_ready[w_p_rs1] || (bus.wb_valid && (bus.wb_prd == w_p_rs1));
  assign bus.p_rs2_rdy  = w_rs2_zero || r_ready[w_p_rs2] || (bus.wb_valid && (bus.wb_prd == w_p_rs2));
  assign bus.p_rd_new   = w_p_rd_new;
  assign bus.p_rd_old   = r_rmt[bus.rn_rd];
  assign bus.free_count = r_free_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < AREGS; i++) begin
        r_rmt[i] <= PW'(i);
        r_cmt[i] <= PW'(i);
      end
      for (int k = 0; k < FDEPTH; k++) begin
        r_free[k] <= PW'(AREGS + k);
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_free_count <= FULL_COUNT;
      r_ready      <= '1;
    end else begin
      // Commits proceed normally even during recover; the restore below sees them.
      if (w_push) begin
        r_cmt[bus.cm_ard] <= bus.cm_prd_new;
        r_free[r_tail]    <= bus.cm_prd_old;
      end
      r_tail <= w_tail_next;

      if (bus.recover) begin
        // Restore from CMT including this cycle's commit; every popped-but-uncommitted
        // register sits between tail and head, so head <- tail returns them all.
        for (int i = 0; i < AREGS; i++) begin
          r_rmt[i] <= (w_push && (bus.cm_ard == AW'(i))) ? bus.cm_prd_new : r_cmt[i];
        end
        r_head       <= w_tail_next;
        r_free_count <= FULL_COUNT;
        r_ready      <= '1;
      end else begin
        if (w_pop) begin
          r_rmt[bus.rn_rd] <= w_p_rd_new;
          r_head           <= w_head_inc;
        end
        case ({w_push, w_pop})
          2'b10:   r_free_count <= r_free_count + 1'b1;
          2'b01:   r_free_count <= r_free_count - 1'b1;
          default: r_free_count <= r_free_count;
        endcase
        if (bus.wb_valid) begin
          r_ready[bus.wb_prd] <= 1'b1;
        end
        // Placed after the writeback so the allocation's clear wins on a collision.
        if (w_pop) begin
          r_ready[w_p_rd_new] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rename_unit.sv
// tb/tb_rename_unit.sv - self-checking bench for rename_unit with a queue-based rename model
module tb_rename_unit;
  localparam int AREGS   = 64;
  localparam int PREGS   = 80;
  localparam int FDEPTH  = PREGS - AREGS;
  localparam int PREGS_W = 70;
  localparam int FDEP_W  = PREGS_W - AREGS;
  localparam int AW      = 6;
  localparam int PW      = 7;

  typedef logic [PW-1:0] preg_t;
  typedef logic [PW:0]   cnt_t;
  typedef logic [AW-1:0] areg_t;
  typedef struct packed { areg_t ard; preg_t pn; preg_t po; } rob_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rename_unit_if #(.AW(AW), .PW(PW)) bus ();
  rename_unit_if #(.AW(AW), .PW(PW)) wbus ();

  rename_unit #(.AREGS(AREGS), .PREGS(PREGS), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rename_unit #(.AREGS(AREGS), .PREGS(PREGS_W), .ZERO_REG(1)) dut_w (
    .clk(clk), .rst(rst), .bus(wbus)
  );

  // Reference model: maps as arrays, free list and in-flight writers as queues.
  preg_t m_rmt [AREGS];
  preg_t m_cmt [AREGS];
  logic  m_rdy [PREGS];
  preg_t m_free [$];
  rob_t  m_rob [$];

  task automatic idle();
    bus.rn_valid = 1'b0;  bus.rn_rd_we = 1'b0;  bus.rn_rs1 = '0;  bus.rn_rs2 = '0;  bus.rn_rd = '0;
    bus.wb_valid = 1'b0;  bus.wb_prd = '0;  bus.cm_valid = 1'b0;  bus.cm_ard = '0;
    bus.cm_prd_new = '0;  bus.cm_prd_old = '0;  bus.recover = 1'b0;
    wbus.rn_valid = 1'b0; wbus.rn_rd_we = 1'b0; wbus.rn_rs1 = '0; wbus.rn_rs2 = '0; wbus.rn_rd = '0;
    wbus.wb_valid = 1'b0; wbus.wb_prd = '0; wbus.cm_valid = 1'b0; wbus.cm_ard = '0;
    wbus.cm_prd_new = '0; wbus.cm_prd_old = '0; wbus.recover = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_rn(input logic v, input logic we, input int rd, input int rs1, input int rs2);
    bus.rn_valid = v;
    bus.rn_rd_we = we;
    bus.rn_rd    = AW'(rd);
    bus.rn_rs1   = AW'(rs1);
    bus.rn_rs2   = AW'(rs2);
  endtask

  task automatic model_init();
    for (int i = 0; i < AREGS; i++) begin
      m_rmt[i] = PW'(i);
      m_cmt[i] = PW'(i);
    end
    for (int p = 0; p < PREGS; p++) m_rdy[p] = 1'b1;
    m_free.delete();
    for (int k = 0; k < FDEPTH; k++) m_free.push_back(PW'(AREGS + k));
    m_rob.delete();
  endtask

  task automatic test_reset();
    do_reset();
    set_rn(1'b1, 1'b1, 7, 5, 6);
    #1;
    n_cmp++; if (bus.p_rs1 !== 7'd5) begin n_bad++; $display("FAIL reset_p_rs1: got %0d want 5", bus.p_rs1); end
    n_cmp++; if (bus.p_rs2 !== 7'd6) begin n_bad++; $display("FAIL reset_p_rs2: got %0d want 6", bus.p_rs2); end
    n_cmp++; if (bus.p_rs1_rdy !== 1'b1 || bus.p_rs2_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b%b want 11", bus.p_rs1_rdy, bus.p_rs2_rdy); end
    n_cmp++; if (bus.p_rd_new !== 7'd64) begin n_bad++; $display("FAIL reset_p_rd_new: got %0d want 64", bus.p_rd_new); end
    n_cmp++; if (bus.p_rd_old !== 7'd7) begin n_bad++; $display("FAIL reset_p_rd_old: got %0d want 7", bus.p_rd_old); end
    n_cmp++; if (bus.free_count !== 8'd16) begin n_bad++; $display("FAIL reset_free_count: got %0d want 16", bus.free_count); end
    n_cmp++; if (bus.rn_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rn_ready: got %b want 1", bus.rn_ready); end
    n_cmp++; if (wbus.free_count !== 8'd6) begin n_bad++; $display("FAIL reset_free_count_w: got %0d want 6", wbus.free_count); end
    tick();
    set_rn(1'b1, 1'b0, 0, 7, 0);
    #1;
    n_cmp++; if (bus.p_rs1 !== 7'd64) begin n_bad++; $display("FAIL reset_reader_p: got %0d want 64", bus.p_rs1); end
    n_cmp++; if (bus.p_rs1_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_reader_rdy: got %b want 0", bus.p_rs1_rdy); end
    n_cmp++; if (bus.free_count !== 8'd15) begin n_bad++; $display("FAIL reset_after_pop: got %0d want 15", bus.free_count); end
    idle();
  endtask

  task automatic test_exhaustion();
    do_reset();
    for (int i = 1; i <= FDEPTH; i++) begin
      set_rn(1'b1, 1'b1, i, 0, 0);
      #1;
      n_cmp++; if (bus.rn_ready !== 1'b1 || bus.p_rd_new !== PW'(63 + i)) begin n_bad++; $display("FAIL exh_pop%0d: got rdy=%b p=%0d want rdy=1 p=%0d", i, bus.rn_ready, bus.p_rd_new, 63 + i); end
      tick();
    end
    set_rn(1'b1, 1'b1, 17, 0, 0);
    #1;
    n_cmp++; if (bus.free_count !== 8'd0) begin n_bad++; $display("FAIL exh_count: got %0d want 0", bus.free_count); end
    n_cmp++; if (bus.rn_ready !== 1'b0) begin n_bad++; $display("FAIL exh_stall: got %b want 0", bus.rn_ready); end
    set_rn(1'b1, 1'b0, 17, 0, 0);
    #1;
    n_cmp++; if (bus.rn_ready !== 1'b1) begin n_bad++; $display("FAIL exh_store: got %b want 1", bus.rn_ready); end
    set_rn(1'b1, 1'b1, 0, 0, 0);
    #1;
    n_cmp++; if (bus.rn_ready !== 1'b1) begin n_bad++; $display("FAIL exh_rd0: got %b want 1", bus.rn_ready); end
    set_rn(1'b1, 1'b1, 17, 0, 0);
    bus.cm_valid = 1'b1; bus.cm_ard = 6'd1; bus.cm_prd_new = 7'd64; bus.cm_prd_old = 7'd1;
    #1;
    n_cmp++; if (bus.rn_ready !== 1'b0) begin n_bad++; $display("FAIL exh_push_no_relief: got %b want 0", bus.rn_ready); end
    tick();
    bus.cm_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rn_ready !== 1'b1 || bus.p_rd_new !== 7'd1) begin n_bad++; $display("FAIL exh_resume: got rdy=%b p=%0d want rdy=1 p=1", bus.rn_ready, bus.p_rd_new); end
    tick();
    n_cmp++; if (bus.free_count !== 8'd0 || bus.rn_ready !== 1'b0) begin n_bad++; $display("FAIL exh_refire: got cnt=%0d rdy=%b want 0 0", bus.free_count, bus.rn_ready); end
    idle();
  endtask

  task automatic test_wb_bypass();
    do_reset();
    set_rn(1'b1, 1'b1, 3, 0, 0);
    #1;
    tick();
    set_rn(1'b1, 1'b0, 0, 3, 0);
    #1;
    n_cmp++; if (bus.p_rs1 !== 7'd64 || bus.p_rs1_rdy !== 1'b0) begin n_bad++; $display("FAIL wb_pending: got p=%0d rdy=%b want 64 0", bus.p_rs1, bus.p_rs1_rdy); end
    bus.wb_valid = 1'b1; bus.wb_prd = 7'd64;
    #1;
    n_cmp++; if (bus.p_rs1_rdy !== 1'b1) begin n_bad++; $display("FAIL wb_bypass: got %b want 1", bus.p_rs1_rdy); end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    n_cmp++; if (bus.p_rs1_rdy !== 1'b1) begin n_bad++; $display("FAIL wb_sticky: got %b want 1", bus.p_rs1_rdy); end
    idle();
  endtask

  task automatic test_commit_recover();
    do_reset();
    set_rn(1'b1, 1'b1, 3, 0, 0); #1; tick();
    set_rn(1'b1, 1'b1, 4, 0, 0); #1; tick();
    set_rn(1'b0, 1'b0, 0, 0, 0);
    bus.cm_valid = 1'b1; bus.cm_ard = 6'd3; bus.cm_prd_new = 7'd64; bus.cm_prd_old = 7'd3;
    #1; tick();
    bus.cm_valid = 1'b0;
    bus.recover = 1'b1;
    set_rn(1'b1, 1'b1, 5, 0, 0);
    #1;
    n_cmp++; if (bus.rn_ready !== 1'b0) begin n_bad++; $display("FAIL rec_ready: got %b want 0", bus.rn_ready); end
    tick();
    bus.recover = 1'b0;
    set_rn(1'b0, 1'b0, 0, 3, 4);
    #1;
    n_cmp++; if (bus.p_rs1 !== 7'd64 || bus.p_rs2 !== 7'd4) begin n_bad++; $display("FAIL rec_map: got r3=%0d r4=%0d want 64 4", bus.p_rs1, bus.p_rs2); end
    n_cmp++; if (bus.p_rs1_rdy !== 1'b1 || bus.p_rs2_rdy !== 1'b1) begin n_bad++; $display("FAIL rec_rdy: got %b%b want 11", bus.p_rs1_rdy, bus.p_rs2_rdy); end
    n_cmp++; if (bus.free_count !== 8'd16) begin n_bad++; $display("FAIL rec_count: got %0d want 16", bus.free_count); end
    n_cmp++; if (bus.p_rd_new !== 7'd65 || bus.rn_ready !== 1'b1) begin n_bad++; $display("FAIL rec_next: got p=%0d rdy=%b want 65 1", bus.p_rd_new, bus.rn_ready); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    for (int i = 1; i <= FDEPTH; i++) begin
      set_rn(1'b1, 1'b1, i, 0, 0);
      tick();
    end
    set_rn(1'b1, 1'b1, 17, 0, 0);
    #1;
    n_cmp++; if (bus.rn_ready !== 1'b0) begin n_bad++; $display("FAIL rst_stall_pre: got %b want 0", bus.rn_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rn(1'b0, 1'b1, 17, 0, 0);
    #1;
    n_cmp++; if (bus.free_count !== 8'd16 || bus.rn_ready !== 1'b1) begin n_bad++; $display("FAIL rst_stall_post: got cnt=%0d rdy=%b want 16 1", bus.free_count, bus.rn_ready); end
    for (int i = 1; i <= 17; i++) begin
      bus.rn_rs1 = AW'(i);
      #1;
      n_cmp++; if (bus.p_rs1 !== PW'(i) || bus.p_rs1_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_stall_ident r%0d: got p=%0d rdy=%b want %0d 1", i, bus.p_rs1, bus.p_rs1_rdy, i); end
    end
    idle();
  endtask

  task automatic test_wrap();
    preg_t wf [$];
    preg_t wr [AREGS];
    logic  seen [PREGS_W];
    areg_t rd;
    preg_t pn;
    preg_t po;
    do_reset();
    for (int i = 0; i < AREGS; i++) wr[i] = PW'(i);
    for (int k = 0; k < FDEP_W; k++) wf.push_back(PW'(AREGS + k));
    for (int p = 0; p < PREGS_W; p++) seen[p] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      rd = AW'($urandom_range(1, AREGS - 1));
      wbus.rn_valid = 1'b1; wbus.rn_rd_we = 1'b1; wbus.rn_rd = rd; wbus.rn_rs1 = rd;
      #1;
      pn = wf.pop_front();
      po = wr[rd];
      n_cmp++; if (wbus.rn_ready !== 1'b1 || wbus.p_rd_new !== pn || wbus.p_rd_old !== po) begin n_bad++; $display("FAIL wrap_rename%0d: got rdy=%b new=%0d old=%0d want 1 %0d %0d", n, wbus.rn_ready, wbus.p_rd_new, wbus.p_rd_old, pn, po); end
      tick();
      wbus.rn_valid = 1'b0;
      wbus.cm_valid = 1'b1; wbus.cm_ard = rd; wbus.cm_prd_new = pn; wbus.cm_prd_old = po;
      wr[rd] = pn;
      wf.push_back(po);
      #1;
      n_cmp++; if (wbus.free_count !== cnt_t'(FDEP_W - 1)) begin n_bad++; $display("FAIL wrap_count_mid%0d: got %0d want %0d", n, wbus.free_count, FDEP_W - 1); end
      tick();
      wbus.cm_valid = 1'b0;
      #1;
      n_cmp++; if (wbus.free_count !== cnt_t'(FDEP_W)) begin n_bad++; $display("FAIL wrap_count%0d: got %0d want %0d", n, wbus.free_count, FDEP_W); end
    end
    // Every mapped register must match the model and appear only once.
    for (int i = 0; i < AREGS; i++) begin
      wbus.rn_rs1 = AW'(i);
      #1;
      n_cmp++; if (wbus.p_rs1 !== wr[i]) begin n_bad++; $display("FAIL wrap_map r%0d: got %0d want %0d", i, wbus.p_rs1, wr[i]); end
      n_cmp++; if (seen[wbus.p_rs1] !== 1'b0) begin n_bad++; $display("FAIL wrap_dup r%0d: got duplicate p%0d want unique", i, wbus.p_rs1); end
      seen[wbus.p_rs1] = 1'b1;
    end
    wbus.rn_valid = 1'b1; wbus.rn_rd_we = 1'b1; wbus.rn_rd = 6'd1;
    #1;
    n_cmp++; if (wbus.p_rd_new !== wf[0] || seen[wbus.p_rd_new] !== 1'b0) begin n_bad++; $display("FAIL wrap_free_head: got %0d want %0d (unmapped)", wbus.p_rd_new, wf[0]); end
    idle();
  endtask

  task automatic test_random();
    logic  v, we, wbv, cmv, rec, alloc, e_ready, e_r1, e_r2;
    areg_t rd, rs1, rs2;
    preg_t wbp, e_p1, e_p2, e_old, pn;
    rob_t  cm;
    preg_t nf [$];
    do_reset();
    model_init();
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 4) != 0);
      rd  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, AREGS - 1));
      rs1 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, AREGS - 1));
      rs2 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, AREGS - 1));
      wbv = ($urandom_range(0, 2) == 0);
      wbp = PW'($urandom_range(0, PREGS - 1));
      cmv = (m_rob.size() != 0) && ($urandom_range(0, 2) == 0);
      cm  = cmv ? m_rob[0] : '0;
      rec = ($urandom_range(0, 39) == 0);
      bus.rn_valid = v; bus.rn_rd_we = we; bus.rn_rd = rd; bus.rn_rs1 = rs1; bus.rn_rs2 = rs2;
      bus.wb_valid = wbv; bus.wb_prd = wbp; bus.recover = rec;
      bus.cm_valid = cmv; bus.cm_ard = cm.ard; bus.cm_prd_new = cm.pn; bus.cm_prd_old = cm.po;
      #1;
      alloc   = we && (rd != '0);
      e_ready = !rec && (!alloc || (m_free.size() != 0));
      e_p1    = (rs1 == '0) ? '0 : m_rmt[rs1];
      e_p2    = (rs2 == '0) ? '0 : m_rmt[rs2];
      e_r1    = (rs1 == '0) || m_rdy[e_p1] || (wbv && (wbp == e_p1));
      e_r2    = (rs2 == '0) || m_rdy[e_p2] || (wbv && (wbp == e_p2));
      e_old   = m_rmt[rd];
      n_cmp++; if (bus.rn_ready !== e_ready) begin n_bad++; $display("FAIL rnd%0d_rn_ready: got %b want %b", c, bus.rn_ready, e_ready); end
      n_cmp++; if (bus.p_rs1 !== e_p1 || bus.p_rs1_rdy !== e_r1) begin n_bad++; $display("FAIL rnd%0d_rs1: got %0d/%b want %0d/%b", c, bus.p_rs1, bus.p_rs1_rdy, e_p1, e_r1); end
      n_cmp++; if (bus.p_rs2 !== e_p2 || bus.p_rs2_rdy !== e_r2) begin n_bad++; $display("FAIL rnd%0d_rs2: got %0d/%b want %0d/%b", c, bus.p_rs2, bus.p_rs2_rdy, e_p2, e_r2); end
      n_cmp++; if (bus.p_rd_old !== e_old) begin n_bad++; $display("FAIL rnd%0d_rd_old: got %0d want %0d", c, bus.p_rd_old, e_old); end
      n_cmp++; if (bus.free_count !== cnt_t'(m_free.size())) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", c, bus.free_count, m_free.size()); end
      n_cmp++; if (cmv && (bus.free_count >= cnt_t'(FDEPTH))) begin n_bad++; $display("FAIL rnd%0d_push_full: got count %0d want below %0d", c, bus.free_count, FDEPTH); end
      if (m_free.size() != 0) begin
        n_cmp++; if (bus.p_rd_new !== m_free[0]) begin n_bad++; $display("FAIL rnd%0d_rd_new: got %0d want %0d", c, bus.p_rd_new, m_free[0]); end
      end
      tick();
      if (cmv) begin
        m_cmt[cm.ard] = cm.pn;
        m_free.push_back(cm.po);
        void'(m_rob.pop_front());
      end
      if (rec) begin
        // Uncommitted allocations return ahead of the existing free entries.
        nf.delete();
        foreach (m_rob[i]) nf.push_back(m_rob[i].pn);
        foreach (m_free[i]) nf.push_back(m_free[i]);
        m_free = nf;
        m_rob.delete();
        for (int i = 0; i < AREGS; i++) m_rmt[i] = m_cmt[i];
        for (int p = 0; p < PREGS; p++) m_rdy[p] = 1'b1;
      end else begin
        if (wbv) m_rdy[wbp] = 1'b1;
        if (v && e_ready && alloc) begin
          pn = m_free.pop_front();
          m_rob.push_back(rob_t'{ard: rd, pn: pn, po: m_rmt[rd]});
          m_rmt[rd] = pn;
          m_rdy[pn] = 1'b0;
        end
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_exhaustion();
    test_wb_bypass();
    test_commit_recover();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rename_unit.md
# rename_unit

Parametrised register-rename unit for the out-of-order core: one instruction per cycle, decoupled from the decode logic. It holds the speculative map (RMT), committed map (CMT), circular free list and per-physical-register ready bits. It sits between decode and issue, and receives writeback and commit notifications from the back end. Compared with the first-generation rename logic, it adds parametrised register counts, a separate writeback port for ready tracking, and rename back-pressure when the free list is exhausted.

## Interface
- AREGS, 64, architectural registers (integer + FP; must be < PREGS)
- PREGS, 80, physical registers
- ZERO_REG, 1, when 1 architectural register 0 is hardwired: never renamed, always physical 0, always ready
- Derived: AW = $clog2(AREGS), PW = $clog2(PREGS), FDEPTH = PREGS − AREGS

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rn_valid  in  1  decode offers an instruction
- rn_ready  out  1  rename can accept
- rn_rs1, rn_rs2, rn_rd  in  AW  architectural indices
- rn_rd_we  in  1  instruction writes rd
- p_rs1, p_rs2  out  PW  physical sources
- p_rs1_rdy, p_rs2_rdy  out  1  source value available
- p_rd_new  out  PW  allocated destination (free-list head)
- p_rd_old  out  PW  previous mapping of rn_rd
- wb_valid  in  1  a result was written
- wb_prd  in  PW  physical register written
- cm_valid  in  1  in-order commit of a renamed writer
- cm_ard  in  AW  committed architectural rd
- cm_prd_new, cm_prd_old  in  PW  committed new / old mapping
- recover  in  1  flush all speculative state
- free_count  out  PW+1  registered free-list occupancy

## Operation
- Reset state: RMT[i]=i and CMT[i]=i; free list slot k holds AREGS+k; head=tail=0; free_count=FDEPTH; all ready bits 1. rn_ready=1 after reset.
- alloc = rn_rd_we && !(ZERO_REG && rn_rd==0).
- rn_ready = !recover && (!alloc || free_count != 0). A commit push in the same cycle does not relieve an empty-list stall.
- fire = rn_valid && rn_ready.
- Source lookups:
  - p_rs1 = RMT[rn_rs1] and p_rs2 = RMT[rn_rs2], read before this cycle's update. An instruction whose rs equals its rd therefore gets the old mapping.
  - p_rd_old = RMT[rn_rd].
  - p_rsX_rdy = ready[p_rsX] | (wb_valid && wb_prd == p_rsX).
  - With ZERO_REG, source index 0 gives p=0 and rdy=1.
- On fire && alloc:
  - RMT[rn_rd] ← p_rd_new.
  - ready[p_rd_new] ← 0.
  - head advances.
- On wb_valid: ready[wb_prd] ← 1. If the same cycle also allocates that register, the allocation's clear wins.
- On cm_valid && !(ZERO_REG && cm_ard==0):
  - CMT[cm_ard] ← cm_prd_new.
  - free slot[tail] ← cm_prd_old.
  - tail advances.
- free_count: +1 per push, −1 per pop. A simultaneous push and pop leaves it unchanged.
- Head and tail wrap modulo FDEPTH, which need not be a power of two: they return to 0 after index FDEPTH−1.
- recover has highest priority:
  - RMT ← CMT, including this cycle's commit write.
  - head ← tail after this cycle's push.
  - free_count ← FDEPTH.
  - All ready bits ← 1.
  - No rename fires, since rn_ready=0.
- Commits are in program order, at most one per cycle. Pushing to a full list is illegal; the bench asserts it never happens.

## Timing
- p_* and rn_ready are combinational from inputs and state, so rename has zero latency. State updates at the rising edge of clk.
- Back-to-back fires are allowed every cycle while free_count > 0.
- An instruction with stalled rn_valid holds its outputs stable until it fires.
- rst mid-operation discards everything and returns to the reset state on the next edge, regardless of other inputs.
- recover takes one cycle. rn_ready returns to 1 in the following cycle.

## Test plan
- Reset defaults:
  - Stimulus: assert rst, then rename rn_rs1=5, rn_rs2=6, rn_rd=7.
  - Required: p_rs1=5, p_rs2=6, both rdy=1, p_rd_new=64, p_rd_old=7, free_count=16.
  - Next cycle, a reader of r7 gets p=64 with rdy=0.
- Free-list exhaustion:
  - Stimulus: 16 consecutive renames of rd=1..16.
  - Required: free_count reaches 0 and rn_ready=0 for an alloc instruction.
  - rn_ready stays 1 for a store (rn_rd_we=0) and for rd=0.
  - A stalled alloc with a same-cycle commit push remains stalled; it fires the following cycle.
- Writeback bypass:
  - Stimulus: rename rd=3 to p64, then read rs1=3 in the same cycle as wb_valid with wb_prd=64.
  - Required: p_rs1_rdy=1; ready[64]=1 thereafter.
- Commit and recovery:
  - Stimulus: rename r3→p64 and r4→p65; commit r3 (old=3); then recover.
  - Required: r3 maps to p64, r4 maps to p4, free_count=16, all ready bits 1.
  - The next allocation pops the slot after the one holding p3.
- Wrap-around: with PREGS=70, AREGS=64 (FDEPTH=6), 20 rename/commit pairs -> head and tail wrap 5→0 without losing or duplicating any physical register; the bench tracks the live set.
- Reset mid-stall: with free_count=0 and rn_valid high, assert rst -> next cycle free_count=16, RMT is identity and rn_ready=1.
